// File: rtl/byte_packer.sv
// Packs NBYTES accepted bytes into one word on a valid/ready output, first byte most-significant.
// Define PACKER_LITTLE_ENDIAN_EN to place the first byte in the least-significant lane instead.
module byte_packer #(
    parameter int BYTE_W = 8,
    parameter int NBYTES = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [BYTE_W-1:0]          in_byte,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [BYTE_W*NBYTES-1:0]   out_word,
    input  logic                       out_ready,
    output logic [$clog2(NBYTES)-1:0]  byte_idx,
    output logic [CNT_W-1:0]           word_cnt
);

    localparam int IDX_W  = $clog2(NBYTES);
    localparam int WORD_W = BYTE_W * NBYTES;

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t              state, state_next;
    logic [WORD_W-1:0]   word_q, word_next;
    logic [IDX_W-1:0]    idx_q, idx_next;
    logic [CNT_W-1:0]    cnt_q, cnt_next;

    function automatic int lane_of(input logic [IDX_W-1:0] idx);
`ifdef PACKER_LITTLE_ENDIAN_EN
        return int'(idx);
`else
        return NBYTES - 1 - int'(idx);
`endif
    endfunction

    function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] word,
                                                  input logic [IDX_W-1:0]  idx,
                                                  input logic [BYTE_W-1:0] data);
        logic [WORD_W-1:0] res;
        res = word;
        res[lane_of(idx)*BYTE_W +: BYTE_W] = data;
        return res;
    endfunction

    assign out_valid = (state == HOLD);
    assign in_ready  = (state == COLLECT) ? 1'b1 : out_ready;
    assign out_word  = word_q;
    assign byte_idx  = idx_q;
    assign word_cnt  = cnt_q;

    always_comb begin
        state_next = state;
        word_next  = word_q;
        idx_next   = idx_q;
        cnt_next   = cnt_q;
        case (state)
            COLLECT: begin
                // flush wins over a same-cycle byte: the byte is dropped
                if (flush) begin
                    idx_next = '0;
                end else if (in_valid) begin
                    word_next = put_byte(word_q, idx_q, in_byte);
                    if (idx_q == IDX_W'(NBYTES - 1)) begin
                        idx_next   = '0;
                        state_next = HOLD;
                    end else begin
                        idx_next = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                // Delivery and the first byte of the next word can share a cycle
                if (out_ready) begin
                    cnt_next   = cnt_q + CNT_W'(1);
                    state_next = COLLECT;
                    if (in_valid) begin
                        word_next = put_byte(word_q, '0, in_byte);
                        idx_next  = IDX_W'(1);
                    end
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= COLLECT;
            word_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_next;
            word_q <= word_next;
            idx_q  <= idx_next;
            cnt_q  <= cnt_next;
        end
    end

endmodule

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer: directed scenarios plus a randomized run against a byte-queue model.
module tb_byte_packer;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_word;
    logic        out_ready;
    logic [1:0]  byte_idx;
    logic [15:0] word_cnt;

    int checks = 0;
    int failures = 0;

    byte_packer #(.BYTE_W(8), .NBYTES(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .out_valid(out_valid), .out_word(out_word), .out_ready(out_ready),
        .byte_idx(byte_idx), .word_cnt(word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word from four bytes in arrival order
    function automatic logic [31:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
`ifdef PACKER_LITTLE_ENDIAN_EN
        return {d, c, b, a};
`else
        return {a, b, c, d};
`endif
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_byte = 8'h00;
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_byte = 8'h5a; out_ready = 1'b1; flush = 1'b0;
        repeat (2) cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_word !== 32'h0) begin failures++; $display("FAIL reset_out_word got=%h exp=0", out_word); end
        checks++; if (byte_idx !== 2'd0) begin failures++; $display("FAIL reset_byte_idx got=%0d exp=0", byte_idx); end
        checks++; if (word_cnt !== 16'd0) begin failures++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_packing();
        logic [7:0] b [4];
        b[0] = 8'hf1; b[1] = 8'hf2; b[2] = 8'hf3; b[3] = 8'hf4;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_byte = b[i];
            @(negedge clk);
            checks++; if (byte_idx !== 2'(i)) begin failures++; $display("FAIL pack_byte_idx i=%0d got=%0d exp=%0d", i, byte_idx, i); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL pack_in_ready i=%0d got=%b exp=1", i, in_ready); end
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pack_early_valid i=%0d got=%b exp=0", i, out_valid); end
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pack_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_word !== pack4(b[0], b[1], b[2], b[3])) begin failures++; $display("FAIL pack_out_word got=%h exp=%h", out_word, pack4(b[0], b[1], b[2], b[3])); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL pack_hold_in_ready got=%b exp=0", in_ready); end
        checks++; if (word_cnt !== 16'd0) begin failures++; $display("FAIL pack_word_cnt0 got=%0d exp=0", word_cnt); end
        checks++; if (byte_idx !== 2'd0) begin failures++; $display("FAIL pack_hold_idx got=%0d exp=0", byte_idx); end
        cyc();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pack_still_held got=%b exp=1", out_valid); end
        cyc();
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL pack_passthru_ready got=%b exp=1", in_ready); end
        cyc();
        out_ready = 1'b0;
        @(negedge clk);
        checks++; if (word_cnt !== 16'd1) begin failures++; $display("FAIL pack_word_cnt1 got=%0d exp=1", word_cnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pack_after_deliver got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got[$];
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 8);
            in_byte  = 8'(i + 1);
            @(negedge clk);
            if (i < 8) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready cycle=%0d got=%b exp=1", i, in_ready); end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_word);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (got.size() != 2) begin
            failures++; $display("FAIL b2b_word_count got=%0d exp=2", got.size());
        end else begin
            if (got[0] !== pack4(8'h01, 8'h02, 8'h03, 8'h04)) begin failures++; $display("FAIL b2b_word0 got=%h exp=%h", got[0], pack4(8'h01, 8'h02, 8'h03, 8'h04)); end
            checks++;
            if (got[1] !== pack4(8'h05, 8'h06, 8'h07, 8'h08)) begin failures++; $display("FAIL b2b_word1 got=%h exp=%h", got[1], pack4(8'h05, 8'h06, 8'h07, 8'h08)); end
        end
        @(negedge clk);
        checks++; if (word_cnt !== 16'd2) begin failures++; $display("FAIL b2b_word_cnt got=%0d exp=2", word_cnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        logic [7:0] b [4];
        logic [31:0] exp_w;
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
        exp_w = pack4(b[0], b[1], b[2], b[3]);
        do_reset();
        in_valid = 1'b1; in_byte = 8'haa; cyc();
        in_byte = 8'hbb; cyc();
        flush = 1'b1; in_byte = 8'hcc;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (byte_idx !== 2'd0) begin failures++; $display("FAIL flush_byte_idx got=%0d exp=0", byte_idx); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_byte = b[i]; cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_word !== exp_w) begin failures++; $display("FAIL flush_out_word got=%h exp=%h", out_word, exp_w); end
        // flush while holding must leave the complete word alone
        flush = 1'b1; in_valid = 1'b1; in_byte = 8'h55;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_hold_valid got=%b exp=1", out_valid); end
        checks++; if (out_word !== exp_w) begin failures++; $display("FAIL flush_hold_word got=%h exp=%h", out_word, exp_w); end
        checks++; if (byte_idx !== 2'd0) begin failures++; $display("FAIL flush_hold_idx got=%0d exp=0", byte_idx); end
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
    endtask

    task automatic test_reset_hold();
        logic [7:0] b [4];
        b[0] = 8'hde; b[1] = 8'had; b[2] = 8'hbe; b[3] = 8'hef;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_byte = b[i]; cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_word !== pack4(b[0], b[1], b[2], b[3]) || out_valid !== 1'b1) begin failures++; $display("FAIL rsthold_word got=%h/%b exp=%h/1", out_word, out_valid, pack4(b[0], b[1], b[2], b[3])); end
        reset = 1'b1; out_ready = 1'b1;
        cyc();
        reset = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rsthold_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_word !== 32'h0) begin failures++; $display("FAIL rsthold_out_word got=%h exp=0", out_word); end
        checks++; if (byte_idx !== 2'd0) begin failures++; $display("FAIL rsthold_byte_idx got=%0d exp=0", byte_idx); end
        checks++; if (word_cnt !== 16'd0) begin failures++; $display("FAIL rsthold_word_cnt got=%0d exp=0", word_cnt); end
    endtask

    task automatic test_gapped();
        logic [7:0] b [4];
        int exp_idx;
        b[0] = 8'hf1; b[1] = 8'hf2; b[2] = 8'hf3; b[3] = 8'hf4;
        do_reset();
        exp_idx = 0;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(1, 3)) begin
                in_valid = 1'b0; in_byte = 8'($urandom);
                @(negedge clk);
                checks++; if (byte_idx !== 2'(exp_idx)) begin failures++; $display("FAIL gap_idle_idx got=%0d exp=%0d", byte_idx, exp_idx); end
                cyc();
            end
            in_valid = 1'b1; in_byte = b[i];
            @(negedge clk);
            checks++; if (byte_idx !== 2'(exp_idx)) begin failures++; $display("FAIL gap_accept_idx got=%0d exp=%0d", byte_idx, exp_idx); end
            cyc();
            exp_idx = (exp_idx + 1) % 4;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (byte_idx !== 2'd0) begin failures++; $display("FAIL gap_final_idx got=%0d exp=0", byte_idx); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL gap_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_word !== pack4(b[0], b[1], b[2], b[3])) begin failures++; $display("FAIL gap_out_word got=%h exp=%h", out_word, pack4(b[0], b[1], b[2], b[3])); end
    endtask

    // Model: a queue of bytes collected so far plus an optional complete word awaiting delivery
    task automatic test_random();
        logic [7:0]  part[$];
        logic        held;
        logic [31:0] held_word;
        logic [15:0] exp_cnt;
        logic        acc, dlv;
        do_reset();
        held = 1'b0; held_word = '0; exp_cnt = '0;
        for (int n = 0; n < 2000; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_byte   = 8'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            checks++; if (out_valid !== held) begin failures++; $display("FAIL rand_out_valid n=%0d got=%b exp=%b", n, out_valid, held); end
            if (held) begin
                checks++; if (out_word !== held_word) begin failures++; $display("FAIL rand_out_word n=%0d got=%h exp=%h", n, out_word, held_word); end
            end
            checks++; if (in_ready !== (!held || out_ready)) begin failures++; $display("FAIL rand_in_ready n=%0d got=%b exp=%b", n, in_ready, !held || out_ready); end
            checks++; if (byte_idx !== 2'(part.size())) begin failures++; $display("FAIL rand_byte_idx n=%0d got=%0d exp=%0d", n, byte_idx, part.size()); end
            checks++; if (word_cnt !== exp_cnt) begin failures++; $display("FAIL rand_word_cnt n=%0d got=%0d exp=%0d", n, word_cnt, exp_cnt); end
            dlv = held && out_ready;
            acc = in_valid && (!held || out_ready);
            if (!held && flush) begin
                part.delete();
            end else if (acc) begin
                part.push_back(in_byte);
            end
            if (dlv) begin
                exp_cnt = exp_cnt + 16'd1;
                held = 1'b0;
            end
            if (part.size() == 4) begin
                held_word = pack4(part[0], part[1], part[2], part[3]);
                held = 1'b1;
                part.delete();
            end
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
        test_reset();
        test_packing();
        test_back_to_back();
        test_flush();
        test_reset_hold();
        test_gapped();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
